// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, polarity normalisation and a
// counter-qualified debounce FSM producing level, press/release pulses and a toggle.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_toggle
);

  localparam int unsigned BW_CNT = $clog2(DEBOUNCE_CYCLES);
  localparam logic [BW_CNT-1:0] CntMax = BW_CNT'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  state_e            state_q, state_d;
  logic [BW_CNT-1:0] cnt_q, cnt_d;
  logic [1:0]        sync_q;
  logic              s;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              toggle_q, toggle_d;

  // Synchronised pin, normalised so that 1 always means pressed.
  assign s = sync_q[1] ^ ACTIVE_LOW;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StReleased: begin
        if (s) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!s) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StPressed;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPressed: begin
        if (!s) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
      end
      StReleaseWait: begin
        if (s) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StReleased;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the accepting edge.
  always_comb begin
    level_d   = (state_d == StPressed) || (state_d == StReleaseWait);
    press_d   = (state_q == StPressWait) && (state_d == StPressed);
    release_d = (state_q == StReleaseWait) && (state_d == StReleased);
    toggle_d  = toggle_q ^ press_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= {2{ACTIVE_LOW}};
      state_q   <= StReleased;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_in};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_toggle  = toggle_q;

endmodule
